// File: rtl/mm_pkg.sv
// Shared constants and types for the matrix-multiply D read path.
`timescale 1ns/1ps
package mm_pkg;

  localparam int unsigned D_W_DEF          = 32;
  localparam int unsigned N1_DEF           = 4;
  localparam int unsigned ADDR_W_DEF       = 12;
  localparam int unsigned MATRIXSIZE_W_DEF = 16;
  localparam int unsigned FIFO_DEPTH       = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/mem_read_d_if.sv
// Output stream towards the host/DMA side: data, valid/ready handshake and end-of-matrix marker.
`timescale 1ns/1ps
interface mem_read_d_if
  import mm_pkg::*;
#(
  parameter int unsigned D_W = D_W_DEF
) ();

  logic [D_W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; reset clears storage too.
`timescale 1ns/1ps
module rd_skid_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             valid,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  assign do_push = push && (cnt_q != CntW'(Depth));
  assign do_pop  = pop && (cnt_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_read_d.sv
// Drains the N1 D result banks address-major onto one valid/ready stream, with credit-limited
// read issue so the return FIFO can never overflow under backpressure.
`timescale 1ns/1ps
module mem_read_d
  import mm_pkg::*;
#(
  parameter int unsigned D_W          = D_W_DEF,
  parameter int unsigned N1           = N1_DEF,
  parameter int unsigned MATRIXSIZE_W = MATRIXSIZE_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [MATRIXSIZE_W-1:0] M1xM3dN1,
  output logic [N1*ADDR_W-1:0]    rd_addr_bram,
  output logic [N1-1:0]           rd_en_bram,
  input  logic [N1*D_W-1:0]       rd_data_bram,
  mem_read_d_if.master            strm,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned LOG_N1 = $clog2(N1);
  localparam int unsigned BANK_W = (N1 > 1) ? LOG_N1 : 1;
  localparam int unsigned CNT_W  = MATRIXSIZE_W + LOG_N1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W  = FCNT_W + 1;

  rd_state_e             state_q, state_d;
  logic [MATRIXSIZE_W-1:0] count_q, count_d, cur_cnt;
  logic [CNT_W-1:0]      total_q, total_d, pop_cnt_q;
  logic [ADDR_W-1:0]     addr_q, addr_d, cur_addr, rd_addr_q, rd_addr_d;
  logic [BANK_W-1:0]     bank_q, bank_d, cur_bank, b1_q, b2_q;
  logic [N1-1:0]         rd_en_q, rd_en_d;
  logic                  v2_q, done_q, done_d, issue, issue_ok, pop;
  logic [OCC_W-1:0]      occ;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_valid, out_last;
  logic [D_W-1:0]        fifo_head;
  logic [N1-1:0][D_W-1:0] rd_data_arr;

  // Credits: everything already issued (rd_en stage, BRAM stage) plus what sits in the FIFO.
  assign occ      = OCC_W'(fifo_count) + OCC_W'(|rd_en_q) + OCC_W'(v2_q);
  assign issue_ok = occ < OCC_W'(FIFO_DEPTH);
  assign pop      = fifo_valid && strm.out_ready;
  assign out_last = fifo_valid && (pop_cnt_q == total_q - CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    total_d   = total_q;
    addr_d    = addr_q;
    bank_d    = bank_q;
    rd_en_d   = '0;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    cur_addr  = addr_q;
    cur_bank  = bank_q;
    cur_cnt   = count_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          count_d = M1xM3dN1;
          total_d = CNT_W'(M1xM3dN1) << LOG_N1;
          if (M1xM3dN1 == '0) begin
            done_d = 1'b1;
          end else begin
            // The first read goes out on the start cycle so rd_en is visible one cycle later.
            issue    = 1'b1;
            cur_addr = '0;
            cur_bank = '0;
            cur_cnt  = M1xM3dN1;
            state_d  = StIssue;
          end
        end
      end
      StIssue: issue = issue_ok;
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (issue) begin
      rd_en_d   = N1'(1) << cur_bank;
      rd_addr_d = cur_addr;
      if (cur_bank == BANK_W'(N1 - 1)) begin
        bank_d = '0;
        addr_d = cur_addr + ADDR_W'(1);
        if (cur_addr == ADDR_W'(cur_cnt - MATRIXSIZE_W'(1))) state_d = StDrain;
      end else begin
        bank_d = cur_bank + BANK_W'(1);
        addr_d = cur_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      total_q   <= '0;
      addr_q    <= '0;
      bank_q    <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      b1_q      <= '0;
      v2_q      <= 1'b0;
      b2_q      <= '0;
      pop_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      total_q   <= total_d;
      addr_q    <= addr_d;
      bank_q    <= bank_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      if (issue) b1_q <= cur_bank;
      v2_q      <= |rd_en_q;
      b2_q      <= b1_q;
      done_q    <= done_d;
      if (state_q == StIdle && start) pop_cnt_q <= '0;
      else if (pop)                   pop_cnt_q <= pop_cnt_q + CNT_W'(1);
    end
  end

  assign rd_data_arr = rd_data_bram;

  rd_skid_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (D_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (v2_q),
    .push_data (rd_data_arr[b2_q]),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign rd_addr_bram   = {N1{rd_addr_q}};
  assign rd_en_bram     = rd_en_q;
  assign strm.out_data  = fifo_head;
  assign strm.out_valid = fifo_valid;
  assign strm.out_last  = out_last;
  assign busy           = (state_q != StIdle);
  assign done           = done_q;

endmodule

// File: tb/tb_mem_read_d.sv
// Directed bench for mem_read_d: BRAM model with word = bank*256 + addr, cycle-exact checks.
`timescale 1ns/1ps
module tb_mem_read_d;
  import mm_pkg::*;

  localparam int N1 = 4;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [15:0]       m1;
  logic [N1*12-1:0]  rd_addr_bram;
  logic [N1-1:0]     rd_en_bram;
  logic [N1*32-1:0]  rd_data_bram = '0;
  logic              busy, done;

  mem_read_d_if #(.D_W(32)) strm ();

  mem_read_d dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .M1xM3dN1     (m1),
    .rd_addr_bram (rd_addr_bram),
    .rd_en_bram   (rd_en_bram),
    .rd_data_bram (rd_data_bram),
    .strm         (strm),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < N1; b++)
      if (rd_en_bram[b])
        rd_data_bram[b*32 +: 32] <= 32'(b * 256) + 32'(rd_addr_bram[b*12 +: 12]);
  end

  int n_vec = 0, n_err = 0;
  int t, n_words, order_err, last_cnt, last_idx, last_off, first_valid, done_off, done_cnt;
  int busy_cnt, rden_cnt, valid_cnt, max_outst, stab_err, onehot_err;
  int last_addr_bank [N1];
  logic        prev_stall, prev_last;
  logic [31:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start a drain on the current (post-negedge) cycle T and collect statistics per cycle.
  task automatic run_drain(input int cnt, input bit rand_ready, input int start2_off,
                           input int budget);
    int outst;
    logic [31:0] exp_w;
    n_words = 0; order_err = 0; last_cnt = 0; last_idx = -1; last_off = -1;
    first_valid = -1; done_off = -1; done_cnt = 0; busy_cnt = 0; rden_cnt = 0;
    valid_cnt = 0; max_outst = 0; stab_err = 0; onehot_err = 0; prev_stall = 1'b0;
    prev_last = 1'b0; prev_data = '0;
    for (int b = 0; b < N1; b++) last_addr_bank[b] = -1;
    m1 = 16'(cnt);
    start = 1'b1;
    t = 0;
    while (t < budget && !(done_off >= 0 && t >= done_off + 3)) begin
      @(negedge clk);
      t++;
      start = (t == start2_off);
      if (t == start2_off) m1 = 16'd5;
      strm.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_en_bram != '0) begin
        rden_cnt++;
        if (!$onehot(rd_en_bram)) onehot_err++;
        for (int b = 0; b < N1; b++)
          if (rd_en_bram[b]) last_addr_bank[b] = int'(rd_addr_bram[b*12 +: 12]);
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_off < 0) done_off = t;
      end
      if (strm.out_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = t;
      end
      if (prev_stall && (!strm.out_valid || strm.out_data !== prev_data ||
                         strm.out_last !== prev_last)) stab_err++;
      prev_stall = strm.out_valid && !strm.out_ready;
      prev_data  = strm.out_data;
      prev_last  = strm.out_last;
      outst = rden_cnt - n_words;
      if (outst > max_outst) max_outst = outst;
      if (strm.out_valid && strm.out_ready) begin
        exp_w = 32'((n_words % N1) * 256 + n_words / N1);
        if (n_words >= cnt * N1 || strm.out_data !== exp_w) order_err++;
        if (strm.out_last) begin
          last_cnt++;
          last_idx = n_words;
          last_off = t;
        end
        n_words++;
      end
    end
    start = 1'b0;
    strm.out_ready = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_en"},   64'(rd_en_bram),     0);
    check({tag, "_rd_addr"}, 64'(rd_addr_bram),   0);
    check({tag, "_valid"},   64'(strm.out_valid), 0);
    check({tag, "_last"},    64'(strm.out_last),  0);
    check({tag, "_data"},    64'(strm.out_data),  0);
    check({tag, "_busy"},    64'(busy),           0);
    check({tag, "_done"},    64'(done),           0);
  endtask

  initial begin
    int vcnt;
    rst = 1'b1;
    start = 1'b0;
    m1 = '0;
    strm.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // count=2, ready=1: exact cycle timing
    run_drain(2, 1'b0, -1, 100);
    check("t1_words", n_words, 8);
    check("t1_order", order_err, 0);
    check("t1_first_valid", first_valid, 3);
    check("t1_last_off", last_off, 10);
    check("t1_last_cnt", last_cnt, 1);
    check("t1_done_off", done_off, 11);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_onehot", onehot_err, 0);

    // count=3, random backpressure
    run_drain(3, 1'b1, -1, 300);
    check("t2_words", n_words, 12);
    check("t2_order", order_err, 0);
    check("t2_stable", stab_err, 0);
    check("t2_outst_le4", max_outst <= 4, 1);
    check("t2_last_idx", last_idx, 11);
    check("t2_done_cnt", done_cnt, 1);

    // count=0: done only
    run_drain(0, 1'b0, -1, 20);
    check("t3_done_off", done_off, 1);
    check("t3_busy", busy_cnt, 0);
    check("t3_rden", rden_cnt, 0);
    check("t3_valid", valid_cnt, 0);

    // count=1 with an ignored start mid-drain
    run_drain(1, 1'b0, 4, 100);
    check("t4_words", n_words, 4);
    check("t4_order", order_err, 0);
    check("t4_last_idx", last_idx, 3);
    check("t4_last_cnt", last_cnt, 1);
    check("t4_rden", rden_cnt, 4);
    check("t4_done_off", done_off, 7);
    check("t4_done_cnt", done_cnt, 1);

    // reset at T+5 of a count=4 drain
    m1 = 16'd4;
    start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    vcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (strm.out_valid || rd_en_bram != '0) vcnt++;
    end
    check("t5_no_stale", vcnt, 0);
    run_drain(2, 1'b0, -1, 100);
    check("t5_words", n_words, 8);
    check("t5_order", order_err, 0);
    check("t5_first_valid", first_valid, 3);
    check("t5_done_off", done_off, 11);

    // count=4096: full address range
    run_drain(4096, 1'b0, -1, 16500);
    check("t6_words", n_words, 16384);
    check("t6_order", order_err, 0);
    check("t6_last_cnt", last_cnt, 1);
    check("t6_last_idx", last_idx, 16383);
    check("t6_done_off", done_off, 16387);
    for (int b = 0; b < N1; b++) check("t6_final_addr", last_addr_bank[b], 4095);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
